// File: rtl/cref_rst_pkg.sv
// Shared types and defaults for the SERDES reset sequencer: state encoding, the
// registered reset-output bundle and the per-state output decode.
package cref_rst_pkg;

    typedef enum logic [2:0] {
        QUAD_RST = 3'd0,
        WAIT_PLL = 3'd1,
        TX_UP    = 3'd2,
        RX_RST   = 3'd3,
        WAIT_CDR = 3'd4,
        RUN      = 3'd5
    } seq_state_t;

    localparam int DEF_QUAD_RST_CYC    = 16;
    localparam int DEF_RX_RST_CYC      = 16;
    localparam int DEF_LOCK_STABLE_CYC = 1024;
    localparam int DEF_CDR_STABLE_CYC  = 1024;
    localparam int DEF_PLL_TIMEOUT_CYC = 65536;
    localparam int DEF_CDR_TIMEOUT_CYC = 65536;

    typedef struct packed {
        logic quad;
        logic tx_pcs;
        logic rx_serdes;
        logic rx_pcs;
        logic link;
    } rst_out_t;

    localparam rst_out_t RST_ALL = '{quad: 1'b1, tx_pcs: 1'b1, rx_serdes: 1'b1,
                                     rx_pcs: 1'b1, link: 1'b0};

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Resets released progressively as the sequence advances; TX stays released
    // on every state past TX_UP so an RX-only retry never disturbs the TX side.
    function automatic rst_out_t state_outputs(input seq_state_t s);
        rst_out_t o;
        o = RST_ALL;
        case (s)
            WAIT_PLL: o.quad = 1'b0;
            TX_UP, RX_RST: begin
                o.quad   = 1'b0;
                o.tx_pcs = 1'b0;
            end
            WAIT_CDR: begin
                o.quad      = 1'b0;
                o.tx_pcs    = 1'b0;
                o.rx_serdes = 1'b0;
            end
            RUN: begin
                o.quad      = 1'b0;
                o.tx_pcs    = 1'b0;
                o.rx_serdes = 1'b0;
                o.rx_pcs    = 1'b0;
                o.link      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cref_sync2.sv
// Two-flop synchronizer, one independent chain per bit, async active-low reset to 0.
module cref_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/cref_serdes_rst_seq.sv
// Reset sequencer for the ECP5 SERDES quad (PCIe x1): quad -> TX PLL lock -> RX CDR lock -> PCS release.
// Define CREF_RST_STATUS_EN to expose seq_state and a saturating retry_cnt.
module cref_serdes_rst_seq
    import cref_rst_pkg::*;
#(
    parameter int QUAD_RST_CYC    = DEF_QUAD_RST_CYC,
    parameter int RX_RST_CYC      = DEF_RX_RST_CYC,
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int CDR_STABLE_CYC  = DEF_CDR_STABLE_CYC,
    parameter int PLL_TIMEOUT_CYC = DEF_PLL_TIMEOUT_CYC,
    parameter int CDR_TIMEOUT_CYC = DEF_CDR_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       rx_cdr_lol,
    input  logic       rx_los,
    output logic       rst_quad,
    output logic       rst_tx_pcs,
    output logic       rst_rx_serdes,
    output logic       rst_rx_pcs,
    output logic       link_ready
`ifdef CREF_RST_STATUS_EN
    ,
    output logic [2:0] seq_state,
    output logic [7:0] retry_cnt
`endif
);

    localparam int CNT_RANGE = max2(max2(max2(QUAD_RST_CYC, RX_RST_CYC),
                                         max2(LOCK_STABLE_CYC, CDR_STABLE_CYC)),
                                    max2(PLL_TIMEOUT_CYC, CDR_TIMEOUT_CYC));
    localparam int CNT_W = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;

    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] QUAD_LAST    = CNT_W'(QUAD_RST_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LAST      = CNT_W'(RX_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CDR_LAST     = CNT_W'(CDR_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] PLL_TMO_LAST = CNT_W'(PLL_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CDR_TMO_LAST = CNT_W'(CDR_TIMEOUT_CYC - 1);

    logic [2:0] sync_in;
    logic [2:0] sync_out;
    logic       pll_ok;
    logic       rx_ok;

    assign sync_in = {pll_lock, rx_cdr_lol, rx_los};

    cref_sync2 #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_out)
    );

    assign pll_ok = sync_out[2];
    assign rx_ok  = !sync_out[1] && !sync_out[0];

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] tmo_reg, tmo_next;
    logic [CNT_W-1:0] cnt_inc;
    rst_out_t         out_reg, out_next;

    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= QUAD_RST;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
            out_reg   <= RST_ALL;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            out_reg   <= out_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;

        case (state_reg)
            QUAD_RST: if (cnt_reg == QUAD_LAST) state_next = WAIT_PLL;
            WAIT_PLL: begin
                if (pll_ok && cnt_reg == LOCK_LAST)
                    state_next = TX_UP;
                else if (tmo_reg == PLL_TMO_LAST)
                    state_next = QUAD_RST;
            end
            TX_UP:    state_next = RX_RST;
            RX_RST:   if (cnt_reg == RX_LAST) state_next = WAIT_CDR;
            WAIT_CDR: begin
                if (rx_ok && cnt_reg == CDR_LAST)
                    state_next = RUN;
                else if (tmo_reg == CDR_TMO_LAST)
                    state_next = RX_RST;
            end
            RUN:      if (!rx_ok) state_next = RX_RST;
            default:  state_next = QUAD_RST;
        endcase

        // Losing the TX PLL invalidates everything downstream of it.
        if (!pll_ok && (state_reg == TX_UP || state_reg == RX_RST ||
                        state_reg == WAIT_CDR || state_reg == RUN))
            state_next = QUAD_RST;

        if (state_next != state_reg) begin
            cnt_next = '0;
            tmo_next = '0;
        end else begin
            tmo_next = (tmo_reg == CNT_SAT) ? tmo_reg : tmo_reg + CNT_W'(1);
            case (state_reg)
                WAIT_PLL: cnt_next = pll_ok ? cnt_inc : '0;
                WAIT_CDR: cnt_next = rx_ok  ? cnt_inc : '0;
                default:  cnt_next = cnt_inc;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    assign out_next = state_outputs(state_next);

    assign rst_quad      = out_reg.quad;
    assign rst_tx_pcs    = out_reg.tx_pcs;
    assign rst_rx_serdes = out_reg.rx_serdes;
    assign rst_rx_pcs    = out_reg.rx_pcs;
    assign link_ready    = out_reg.link;

`ifdef CREF_RST_STATUS_EN
    logic       retry_evt;
    logic [7:0] retry_reg;

    // QUAD_RST is only re-entered on failure; RX_RST only from TX_UP on success.
    assign retry_evt = (state_next == QUAD_RST && state_reg != QUAD_RST) ||
                       (state_next == RX_RST && state_reg != RX_RST && state_reg != TX_UP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_reg <= 8'd0;
        else if (retry_evt && retry_reg != 8'hFF)
            retry_reg <= retry_reg + 8'd1;
    end

    assign seq_state = state_reg;
    assign retry_cnt = retry_reg;
`endif

endmodule
